// File: rtl/mem_arbiter_if.sv
// Client en/done handshakes and memory-side control bus for mem_arbiter.
// The bidirectional memdata bus is a plain port on mem_arbiter, not part of this interface.
interface mem_arbiter_if;
    logic [29:0] iadr;
    logic        ien;
    logic        idone;
    logic [31:0] irdata;

    logic [29:0] dadr;
    logic [31:0] dwdata;
    logic [3:0]  dbyteen;
    logic        drwb;
    logic        den;
    logic        ddone;
    logic [31:0] drdata;

    logic [29:0] wadr;
    logic [31:0] wdata;
    logic [3:0]  wbyteen;
    logic        wen;
    logic        wdone;

    logic [29:0] memadr;
    logic [3:0]  membyteen;
    logic        memrwb;
    logic        memen;
    logic        memdone;

    modport master (
        output iadr, ien, dadr, dwdata, dbyteen, drwb, den, wadr, wdata, wbyteen, wen, memdone,
        input  idone, irdata, ddone, drdata, wdone, memadr, membyteen, memrwb, memen
    );

    modport slave (
        input  iadr, ien, dadr, dwdata, dbyteen, drwb, den, wadr, wdata, wbyteen, wen, memdone,
        output idone, irdata, ddone, drdata, wdone, memadr, membyteen, memrwb, memen
    );
endinterface

// File: rtl/mem_arbiter.sv
// Serialises icache, dcache and write-buffer requests onto one memory port.
// Define MEMARB_RR_EN for round-robin arbitration; default is fixed d > i > w with a starvation guard.
module mem_arbiter (
    input  logic         clk,
    input  logic         reset,
    mem_arbiter_if.slave bus,
    inout  wire  [31:0]  memdata
);
    typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;
    typedef enum logic [1:0] {CL_W = 2'd0, CL_D = 2'd1, CL_I = 2'd2, CL_NONE = 2'd3} client_t;

    state_t      state;
    client_t     owner;
    client_t     winner;
    logic [31:0] memwdata;
    logic        hazard;

    // A dcache read of the address the write buffer is about to store must wait for that store.
    assign hazard  = bus.wen && bus.den && bus.drwb && (bus.dadr == bus.wadr);
    assign memdata = (bus.memen && !bus.memrwb) ? memwdata : 32'hzzzzzzzz;

`ifdef MEMARB_RR_EN
    logic [1:0] rr_ptr;
    logic [1:0] cand;
    logic [2:0] req;

    // Search starts just after the last-granted client, so it becomes lowest priority.
    always_comb begin
        req    = {bus.ien, bus.den, bus.wen};
        winner = CL_NONE;
        cand   = rr_ptr;
        if (hazard) begin
            winner = CL_W;
        end else begin
            for (int k = 0; k < 3; k++) begin
                cand = (cand == 2'd2) ? 2'd0 : cand + 2'd1;
                if (winner == CL_NONE && req[cand]) winner = client_t'(cand);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) rr_ptr <= 2'd0;
        else if (state == IDLE && winner != CL_NONE) rr_ptr <= winner;
    end
`else
    logic [2:0] starve_cnt;

    always_comb begin
        winner = CL_NONE;
        if (hazard || (bus.wen && starve_cnt == 3'd4)) winner = CL_W;
        else if (bus.den) winner = CL_D;
        else if (bus.ien) winner = CL_I;
        else if (bus.wen) winner = CL_W;
    end

    always_ff @(posedge clk) begin
        if (!reset) starve_cnt <= 3'd0;
        else if (!bus.wen || (state == IDLE && winner == CL_W)) starve_cnt <= 3'd0;
        else if (state == IDLE && winner != CL_NONE) starve_cnt <= starve_cnt + 3'd1;
    end
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= IDLE;
            owner         <= CL_NONE;
            bus.memen     <= 1'b0;
            bus.memrwb    <= 1'b1;
            bus.memadr    <= 30'd0;
            bus.membyteen <= 4'd0;
            memwdata      <= 32'd0;
            bus.idone     <= 1'b0;
            bus.ddone     <= 1'b0;
            bus.wdone     <= 1'b0;
            bus.irdata    <= 32'd0;
            bus.drdata    <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (winner != CL_NONE) begin
                        owner     <= winner;
                        bus.memen <= 1'b1;
                        state     <= BUSY;
                        case (winner)
                            CL_D: begin
                                bus.memadr    <= bus.dadr;
                                memwdata      <= bus.dwdata;
                                bus.membyteen <= bus.dbyteen;
                                bus.memrwb    <= bus.drwb;
                            end
                            CL_I: begin
                                bus.memadr    <= bus.iadr;
                                bus.membyteen <= 4'b1111;
                                bus.memrwb    <= 1'b1;
                            end
                            default: begin
                                bus.memadr    <= bus.wadr;
                                memwdata      <= bus.wdata;
                                bus.membyteen <= bus.wbyteen;
                                bus.memrwb    <= 1'b0;
                            end
                        endcase
                    end
                end
                BUSY: begin
                    if (bus.memdone) begin
                        bus.memen <= 1'b0;
                        state     <= ACK;
                        case (owner)
                            CL_D: begin
                                bus.ddone <= 1'b1;
                                if (bus.memrwb) bus.drdata <= memdata;
                            end
                            CL_I: begin
                                bus.idone  <= 1'b1;
                                bus.irdata <= memdata;
                            end
                            CL_W:    bus.wdone <= 1'b1;
                            default: ;
                        endcase
                    end
                end
                ACK: begin
                    bus.idone <= 1'b0;
                    bus.ddone <= 1'b0;
                    bus.wdone <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (default fixed-priority build) with a transaction-level
// reference model, a simple memory responder and a per-cycle compare process.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if bus();
    wire  [31:0] memdata;
    logic [31:0] rd_val = 32'd0;
    assign memdata = (bus.memen && bus.memrwb) ? rd_val : 32'hzzzzzzzz;

    mem_arbiter dut (.clk(clk), .reset(reset), .bus(bus), .memdata(memdata));

    int    total = 0;
    int    bad = 0;
    bit    chk_on = 0;
    string order = "";
    int    memen_cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_str(input string name, input string act, input string exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got \"%s\" want \"%s\"", name, act, exp);
        end
    endtask

    // Memory responder: word store, memdone after mem_delay cycles of memen
    bit [31:0]   mem [int];
    int          mem_delay = 0;
    logic        spurious = 1'b0;
    int          wait_cnt = 0;
    logic [31:0] wv;

    function automatic logic [31:0] mem_rd(input logic [29:0] a);
        if (mem.exists(int'(a))) return mem[int'(a)];
        return 32'h0;
    endfunction

    initial begin
        bus.memdone = 1'b0;
        forever begin
            @(negedge clk);
            rd_val = mem_rd(bus.memadr);
            if (bus.memen) begin
                if (wait_cnt >= mem_delay) begin
                    bus.memdone = 1'b1;
                    if (!bus.memrwb) begin
                        wv = mem_rd(bus.memadr);
                        for (int b = 0; b < 4; b++)
                            if (bus.membyteen[b]) wv[8*b +: 8] = memdata[8*b +: 8];
                        mem[int'(bus.memadr)] = wv;
                    end
                end else begin
                    bus.memdone = 1'b0;
                end
                wait_cnt++;
            end else begin
                bus.memdone = spurious;
                wait_cnt = 0;
            end
        end
    end

    // Reference model: 0 = no request, 1 = dcache, 2 = icache, 3 = write buffer
    int          m_phase, m_own, m_cnt, m_g;
    logic        e_memen, e_rwb, e_idone, e_ddone, e_wdone;
    logic [29:0] e_adr;
    logic [3:0]  e_be;
    logic [31:0] e_wd, e_ird, e_drd;

    function automatic int pick(input logic den, input logic drwb, input logic ien, input logic wen,
                                input logic [29:0] dadr, input logic [29:0] wadr, input int cnt);
        if (wen && den && drwb && dadr == wadr) return 3;
        if (wen && cnt >= 4) return 3;
        if (den) return 1;
        if (ien) return 2;
        if (wen) return 3;
        return 0;
    endfunction

    initial begin
        m_phase = 0; m_own = 0; m_cnt = 0; m_g = 0;
        forever begin
            @(posedge clk);
            if (!reset) begin
                m_phase = 0; m_cnt = 0;
                e_memen = 0; e_rwb = 1; e_adr = 0; e_be = 0; e_wd = 0;
                e_idone = 0; e_ddone = 0; e_wdone = 0; e_ird = 0; e_drd = 0;
            end else begin
                if (m_phase == 2) begin
                    e_idone = 0; e_ddone = 0; e_wdone = 0;
                    m_phase = 0;
                end else if (m_phase == 1) begin
                    if (bus.memdone) begin
                        e_memen = 0;
                        m_phase = 2;
                        if (m_own == 1) begin
                            e_ddone = 1;
                            if (e_rwb) e_drd = mem_rd(e_adr);
                        end else if (m_own == 2) begin
                            e_idone = 1;
                            e_ird = mem_rd(e_adr);
                        end else begin
                            e_wdone = 1;
                        end
                    end
                end else begin
                    m_g = pick(bus.den, bus.drwb, bus.ien, bus.wen, bus.dadr, bus.wadr, m_cnt);
                    if (m_g != 0) begin
                        m_own = m_g; m_phase = 1; e_memen = 1;
                        if (m_g == 1) begin
                            e_adr = bus.dadr; e_wd = bus.dwdata; e_be = bus.dbyteen; e_rwb = bus.drwb;
                        end else if (m_g == 2) begin
                            e_adr = bus.iadr; e_be = 4'hF; e_rwb = 1;
                        end else begin
                            e_adr = bus.wadr; e_wd = bus.wdata; e_be = bus.wbyteen; e_rwb = 0;
                        end
                        if (m_g == 3) m_cnt = 0;
                        else if (bus.wen) m_cnt++;
                    end
                end
                if (!bus.wen) m_cnt = 0;
            end
        end
    end

    // Per-cycle comparison of DUT outputs against the model
    initial forever begin
        @(negedge clk);
        if (chk_on) begin
            chk("memen", bus.memen, e_memen);
            chk("memadr", bus.memadr, e_adr);
            chk("memrwb", bus.memrwb, e_rwb);
            chk("membyteen", bus.membyteen, e_be);
            chk("idone", bus.idone, e_idone);
            chk("ddone", bus.ddone, e_ddone);
            chk("wdone", bus.wdone, e_wdone);
            chk("irdata", bus.irdata, e_ird);
            chk("drdata", bus.drdata, e_drd);
            if (e_memen && !e_rwb) chk("memdata_wr", memdata, e_wd);
            if (bus.idone) order = {order, "I"};
            if (bus.ddone) order = {order, "D"};
            if (bus.wdone) order = {order, "W"};
            if (bus.memen) memen_cyc++;
        end
    end

    // Client drivers: drop en when done is seen, re-raise next cycle if repeats remain
    logic i_arm = 0, d_arm = 0, w_arm = 0;
    int   i_rem = 0, d_rem = 0, w_rem = 0;

    task automatic step();
        @(posedge clk); #1;
        if (bus.idone) begin bus.ien = 0; i_arm = (i_rem > 0); end
        else if (i_arm) begin bus.ien = 1; i_rem--; i_arm = 0; end
        if (bus.ddone) begin bus.den = 0; d_arm = (d_rem > 0); end
        else if (d_arm) begin bus.den = 1; d_rem--; d_arm = 0; end
        if (bus.wdone) begin bus.wen = 0; w_arm = (w_rem > 0); end
        else if (w_arm) begin bus.wen = 1; w_rem--; w_arm = 0; end
    endtask

    task automatic drain(input int maxc, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while ((bus.ien || bus.den || bus.wen || i_arm || d_arm || w_arm) && n < maxc);
        if (n >= maxc) begin
            total++; bad++;
            $display("FAIL drain_timeout: got %0d cycles want < %0d", n, maxc);
        end
        repeat (2) step();
    endtask

    int n;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.ien = 0; bus.iadr = 0;
        bus.den = 0; bus.dadr = 0; bus.dwdata = 0; bus.dbyteen = 0; bus.drwb = 1;
        bus.wen = 0; bus.wadr = 0; bus.wdata = 0; bus.wbyteen = 0;
        repeat (2) @(posedge clk);
        @(negedge clk) chk_on = 1;
        @(negedge clk) reset = 1;
        step();

        // Single write-buffer store
        memen_cyc = 0; order = "";
        bus.wadr = 30'h0; bus.wdata = 32'hDEADBEEF; bus.wbyteen = 4'b0001; bus.wen = 1;
        drain(20, n);
        chk("t1_done_latency", n, 2);
        chk("t1_memen_cycles", memen_cyc, 1);
        chk("t1_mem0", mem_rd(30'h0), 32'h000000EF);
        chk_str("t1_order", order, "W");

        // Reset during BUSY abandons the transaction
        mem_delay = 100; order = "";
        bus.iadr = 30'h5; bus.ien = 1;
        repeat (3) step();
        @(negedge clk) begin reset = 0; bus.ien = 0; end
        repeat (2) @(posedge clk);
        @(negedge clk) begin reset = 1; mem_delay = 0; end
        @(posedge clk); #1;
        chk("t2_memen_after_reset", bus.memen, 1'b0);
        chk("t2_idone_after_reset", bus.idone, 1'b0);
        mem[5] = 32'h00000055;
        bus.ien = 1;
        drain(20, n);
        chk("t2_irdata", bus.irdata, 32'h00000055);
        chk_str("t2_order", order, "I");

        // icache read with slow memory
        mem[32'h12B4] = 32'hAAAAAAAA; mem_delay = 4; memen_cyc = 0; order = "";
        bus.iadr = 30'h12B4; bus.ien = 1;
        drain(40, n);
        chk("t3_done_latency", n, 6);
        chk("t3_memen_cycles", memen_cyc, 5);
        chk("t3_irdata", bus.irdata, 32'hAAAAAAAA);
        chk_str("t3_order", order, "I");
        mem_delay = 0;

        // Simultaneous dcache read and icache read
        mem[32'h10] = 32'h11110000; mem[32'h20] = 32'h22220000; order = "";
        bus.dadr = 30'h10; bus.drwb = 1; bus.dbyteen = 4'hF; bus.den = 1;
        bus.iadr = 30'h20; bus.ien = 1;
        drain(30, n);
        chk_str("t4_order", order, "DI");
        chk("t4_drdata", bus.drdata, 32'h11110000);
        chk("t4_irdata", bus.irdata, 32'h22220000);

        // dcache partial write then read back
        bus.dadr = 30'h80; bus.drwb = 0; bus.dwdata = 32'hCAFEF00D; bus.dbyteen = 4'b1100; bus.den = 1;
        drain(20, n);
        bus.drwb = 1; bus.dbyteen = 4'hF; bus.den = 1;
        drain(20, n);
        chk("t5_drdata", bus.drdata, 32'hCAFE0000);

        // Starvation guard: write buffer wins after four d/i grants
        order = "";
        bus.wadr = 30'h300; bus.wdata = 32'h00000077; bus.wbyteen = 4'hF; bus.wen = 1;
        bus.dadr = 30'h40; bus.drwb = 1; bus.den = 1; d_rem = 4;
        bus.iadr = 30'h50; bus.ien = 1;
        drain(100, n);
        chk_str("t6_order", order, "DDDDWDI");
        chk("t6_mem300", mem_rd(30'h300), 32'h00000077);

        // Read-after-pending-write hazard
        order = "";
        bus.wadr = 30'h4AD; bus.wdata = 32'h12345678; bus.wbyteen = 4'hF; bus.wen = 1;
        bus.dadr = 30'h4AD; bus.drwb = 1; bus.den = 1;
        drain(30, n);
        chk_str("t7_order", order, "WD");
        chk("t7_drdata", bus.drdata, 32'h12345678);

        // memdone asserted outside BUSY has no effect
        spurious = 1; order = "";
        repeat (3) step();
        chk_str("t8_no_done_idle", order, "");
        bus.iadr = 30'h20; bus.ien = 1;
        drain(20, n);
        chk_str("t8_order", order, "I");
        chk("t8_irdata", bus.irdata, 32'h22220000);
        spurious = 0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates the single external memory port among the three memory clients: instruction-cache fills, data-cache fills/uncached accesses, and the write buffer drain. Sits directly downstream of the write buffer and both caches, and upstream of the memory bus interface. Each client uses the existing en/done handshake; the arbiter serialises them into one memen/memdone transaction at a time.

## Interface
- No parameters.
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset (asserted when 0).
- iadr  in  30  icache word address; ien  in  1  icache read request; idone  out  1  icache completion pulse; irdata  out  32  icache read data.
- dadr  in  30  dcache word address; dwdata  in  32  dcache write data; dbyteen  in  4  byte enables; drwb  in  1  1=read, 0=write; den  in  1  request; ddone  out  1  completion pulse; drdata  out  32  dcache read data.
- wadr  in  30  write-buffer head address; wdata  in  32  head data; wbyteen  in  4  head byte enables; wen  in  1  head valid; wdone  out  1  completion pulse.
- memadr  out  30; memdata  inout  32 (driven only when memrwb=0 and memen=1, else Z); membyteen  out  4; memrwb  out  1; memen  out  1; memdone  in  1.

## Operation
- Client handshake: client raises en with stable address/data, holds until it samples done=1, then drops en on that edge.
- States: IDLE, BUSY, ACK.
- IDLE: if any en asserted, pick winner, register its adr/data/byteen/rwb onto mem outputs, record owner, -> BUSY. Else stay.
- BUSY: memen=1, outputs held. On edge with memdone=1: capture memdata into owner's rdata register if read, -> ACK. memdone=0: stay, no timeout.
- ACK: memen=0, owner's done=1 for exactly this one cycle, -> IDLE.
- icache requests are always reads (memrwb=1, membyteen=4'b1111). Write-buffer requests are always writes.
- Fixed priority: d > i > w. Starvation guard: 3-bit counter increments each grant to d or i while wen=1; when it reaches 4, w wins next IDLE decision regardless; cleared on any w grant or when wen=0.
- Hazard rule: a dcache read (den=1, drwb=1) with dadr == wadr while wen=1 is not granted; w is granted instead (pending store drains first). Applies in both arbitration modes.
- irdata/drdata hold their last captured value until the next read completes for that client.
- Reset values: state IDLE, memen 0, memrwb 1, memadr 0, membyteen 0, idone/ddone/wdone 0, irdata/drdata 0, counters and round-robin pointer 0.
- Reset mid-transaction: transaction abandoned, no done issued; memdone ignored outside BUSY.

## Timing
- Request seen at edge k -> memen=1 from k to k+1 onward; memdone=1 sampled at edge k+1 (minimum) -> done=1 during cycle k+1..k+2 -> IDLE at k+2.
- Minimum 3 cycles per transaction with memdone tied high; back-to-back grants every 3 cycles.
- Data returned on rdata is valid in the same cycle done=1 and thereafter.
- Simultaneous en from all three: exactly one grant; others wait with en held, no done.
- memdone asserted while IDLE or ACK: no effect.

## Configuration
- MEMARB_RR_EN defined: round-robin among d, i, w; 2-bit pointer to last-granted client, which becomes lowest priority; starvation counter removed; hazard rule still overrides.
- Undefined: fixed priority d > i > w with starvation guard as above.

## Test plan
- Reset low 2 cycles during BUSY with memdone=0 -> after release memen=0, all done=0, state IDLE; next ien serviced normally.
- wen=1, wadr=0, wdata=DEADBEEF, wbyteen=0001, memdone=1 -> memen=1, memrwb=0, memdata=DEADBEEF, membyteen=0001 one cycle; wdone pulse next cycle; total 3 cycles.
- ien=1 iadr=12B4, memdata driven AAAAAAAA, memdone delayed 4 cycles -> memen held 5 cycles, idone one pulse, irdata=AAAAAAAA.
- den read and ien together -> d granted first, then i; under MEMARB_RR_EN second simultaneous pair alternates.
- wen held, den/ien continuously requesting (fixed mode) -> w granted after 4 d/i grants.
- wen=1 wadr=4AD, den read dadr=4AD -> write granted first, dcache read follows and returns written data from memory model.
